mem_port_arbiter: RTL and testbench

- Shares one single-port memory between the core's instruction-fetch port and its load/store port.
- Sequences each access through a fixed-latency memory: request, grant, hold, response.
- Sits between FloppyComp_V1 and a unified memory.
- Gives the core a req/gnt/rvalid handshake per port and generates the memory enable, write and strobe signals.

---
 rtl/mem_port_arbiter.sv | 228 ++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency single-port memory between the
// instruction-fetch port and the load/store port of the core.
// Each access runs accept (IDLE) -> MEM_LATENCY cycles of mem_en (BUSY) ->
// one response cycle (RESP). Grants are combinational in the accept cycle.
// Optional build macro MEM_PORT_ARB_RR_EN: round-robin arbitration between the
// two ports when both request together; otherwise data always beats fetch.
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(MEM_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                owner_q, owner_d;     // 1 = data port, 0 = fetch port
    logic                we_q, we_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                if_rvalid_q, if_rvalid_d;
    logic                d_rvalid_q, d_rvalid_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic                busy_q, busy_d;
    logic                pick_d_s;
    logic                if_gnt_s;
    logic                d_gnt_s;
    logic [DATA_W-1:0]   rdata_cap_s;
`ifdef MEM_PORT_ARB_RR_EN
    logic                last_owner_q, last_owner_d;  // 1 = data port won last
`endif

    // Winner selection among the current requests (only used in IDLE)
    always_comb begin
        pick_d_s = 1'b0;
`ifdef MEM_PORT_ARB_RR_EN
        if (d_req && if_req) begin
            pick_d_s = ~last_owner_q;
        end else begin
            pick_d_s = d_req;
        end
`else
        pick_d_s = d_req;
`endif
    end

    // Grants are combinational in IDLE and suppressed while reset is held
    always_comb begin
        if_gnt_s    = reset && (state_q == IDLE) && if_req && !pick_d_s;
        d_gnt_s     = reset && (state_q == IDLE) && pick_d_s;
        rdata_cap_s = we_q ? {DATA_W{1'b0}} : mem_rdata;
    end

    // Next-state and next-output computation for the access sequencer
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        we_d        = we_q;
        be_d        = be_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_rvalid_d = if_rvalid_q;
        d_rvalid_d  = d_rvalid_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        busy_d      = busy_q;
`ifdef MEM_PORT_ARB_RR_EN
        last_owner_d = last_owner_q;
`endif
        case (state_q)
            IDLE: begin
                if (d_gnt_s || if_gnt_s) begin
                    state_d  = BUSY;
                    cnt_d    = {CNT_W{1'b0}};
                    owner_d  = d_gnt_s;
                    mem_en_d = 1'b1;
                    busy_d   = 1'b1;
`ifdef MEM_PORT_ARB_RR_EN
                    last_owner_d = d_gnt_s;
`endif
                    if (d_gnt_s) begin
                        we_d     = d_we;
                        be_d     = d_be;
                        addr_d   = d_addr;
                        wdata_d  = d_wdata;
                        mem_we_d = d_we;
                    end else begin
                        // fetches are always full-width reads
                        we_d     = 1'b0;
                        be_d     = {BE_W{1'b1}};
                        addr_d   = if_addr;
                        wdata_d  = {DATA_W{1'b0}};
                        mem_we_d = 1'b0;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d  = RESP;
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    if (owner_q) begin
                        d_rdata_d  = rdata_cap_s;
                        d_rvalid_d = 1'b1;
                    end else begin
                        if_rdata_d  = rdata_cap_s;
                        if_rvalid_d = 1'b1;
                    end
                end else begin
                    state_d = BUSY;
                end
            end
            RESP: begin
                state_d     = IDLE;
                cnt_d       = {CNT_W{1'b0}};
                if_rvalid_d = 1'b0;
                d_rvalid_d  = 1'b0;
                busy_d      = 1'b0;
            end
            default: begin
                state_d     = IDLE;
                cnt_d       = {CNT_W{1'b0}};
                if_rvalid_d = 1'b0;
                d_rvalid_d  = 1'b0;
                mem_en_d    = 1'b0;
                mem_we_d    = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    // State and output registers; reset discards any in-flight access
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            be_q        <= {BE_W{1'b0}};
            addr_q      <= {ADDR_W{1'b0}};
            wdata_q     <= {DATA_W{1'b0}};
            if_rdata_q  <= {DATA_W{1'b0}};
            d_rdata_q   <= {DATA_W{1'b0}};
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            busy_q      <= 1'b0;
`ifdef MEM_PORT_ARB_RR_EN
            last_owner_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            be_q        <= be_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            busy_q      <= busy_d;
`ifdef MEM_PORT_ARB_RR_EN
            last_owner_q <= last_owner_d;
`endif
        end
    end

    assign if_gnt    = if_gnt_s;
    assign d_gnt     = d_gnt_s;
    assign if_rvalid = if_rvalid_q;
    assign d_rvalid  = d_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = be_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed sequences, a vector table
// and randomized traffic, all checked against a cycle-timeline reference model.
module tb_mem_port_arbiter;

    localparam int L = 2;
`ifdef MEM_PORT_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(L)) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_chk = 0;
    int n_err = 0;

    // staged inputs, applied at the next falling edge
    bit          drv_rst, drv_ir, drv_dr, drv_we;
    logic [31:0] drv_iaddr, drv_daddr, drv_wdata;
    logic [3:0]  drv_be;

    // reference model: one access described by its accept cycle
    int          cyc = 0;
    bit          act = 1'b0;
    int          st = 0;
    bit          own_d, m_we, last_d;
    logic [3:0]  m_be;
    logic [31:0] m_addr, m_wdata;
    logic [31:0] exp_ir = 32'h0, exp_dr = 32'h0;
    bit          last_ig, last_dg;
    bit          grants[$];

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h0000_0010) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic set_if(input bit r, input logic [31:0] a);
        drv_ir = r; drv_iaddr = a;
    endtask

    task automatic set_d(input bit r, input bit w, input logic [3:0] b,
                         input logic [31:0] a, input logic [31:0] wd);
        drv_dr = r; drv_we = w; drv_be = b; drv_daddr = a; drv_wdata = wd;
    endtask

    // one clock cycle: apply staged inputs, compare every output with the model
    task automatic step();
        int ph;
        bit own, e_ig, e_dg, e_en, e_we, e_irv, e_drv, e_busy;
        @(negedge clock);
        reset = drv_rst; if_req = drv_ir; if_addr = drv_iaddr;
        d_req = drv_dr; d_we = drv_we; d_be = drv_be; d_addr = drv_daddr; d_wdata = drv_wdata;
        if (!drv_rst) act = 1'b0;
        ph = cyc - st;
        if (act && ph > L + 1) act = 1'b0;
        mem_rdata = (act && ph == L) ? mem_fn(m_addr) : (32'hBAD0_0000 ^ 32'(cyc));
        #1;
        {e_ig, e_dg, e_en, e_we, e_irv, e_drv, e_busy} = 7'b0;
        if (!drv_rst) begin
            exp_ir = 32'h0; exp_dr = 32'h0; last_d = 1'b0;
        end else if (!act) begin
            if (drv_ir || drv_dr) begin
                own = drv_dr && !(RR && drv_ir && last_d);
                e_dg = own; e_ig = !own;
                act = 1'b1; st = cyc; own_d = own; last_d = own;
                m_we    = own ? drv_we : 1'b0;
                m_be    = own ? drv_be : 4'hF;
                m_addr  = own ? drv_daddr : drv_iaddr;
                m_wdata = drv_wdata;
                grants.push_back(own);
            end
        end else if (ph >= 1 && ph <= L) begin
            e_en = 1'b1; e_we = m_we; e_busy = 1'b1;
        end else if (ph == L + 1) begin
            e_busy = 1'b1;
            if (own_d) begin
                e_drv = 1'b1; exp_dr = m_we ? 32'h0 : mem_fn(m_addr);
            end else begin
                e_irv = 1'b1; exp_ir = mem_fn(m_addr);
            end
        end
        chk("if_gnt", 32'(if_gnt), 32'(e_ig));
        chk("d_gnt", 32'(d_gnt), 32'(e_dg));
        chk("mem_en", 32'(mem_en), 32'(e_en));
        chk("mem_we", 32'(mem_we), 32'(e_we));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("if_rvalid", 32'(if_rvalid), 32'(e_irv));
        chk("d_rvalid", 32'(d_rvalid), 32'(e_drv));
        chk("if_rdata", if_rdata, exp_ir);
        chk("d_rdata", d_rdata, exp_dr);
        if (e_en) begin
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_be", 32'(mem_be), 32'(m_be));
            if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
        end
        if (!drv_rst) begin
            chk("rst_mem_addr", mem_addr, 32'h0);
            chk("rst_mem_be", 32'(mem_be), 32'h0);
            chk("rst_mem_wdata", mem_wdata, 32'h0);
        end
        last_ig = e_ig; last_dg = e_dg;
        cyc++;
    endtask

    task automatic idle_wait();
        set_if(1'b0, 32'h0); set_d(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        repeat (L + 2) step();
    endtask

    typedef struct {
        bit          ir;
        bit          dr;
        bit          we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          exp_dg;
        logic [31:0] exp_rdata;
    } vec_t;
    vec_t vecs[4];

    initial begin
        int en_cnt, ig_cnt;
        bit ron_i, ron_d;
        vecs[0] = '{1'b1, 1'b0, 1'b0, 4'h0, 32'h0000_0010, 32'h0, 1'b0, 32'h0050_0093};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 4'h3, 32'h0000_0044, 32'hCAFE_F00D, 1'b1, 32'h0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 4'hF, 32'h0000_0048, 32'h0, 1'b1, mem_fn(32'h48)};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 4'hF, 32'h0000_004C, 32'h0, !RR, mem_fn(32'h4C)};

        reset = 1'b0; if_req = 1'b0; if_addr = 32'h0; d_req = 1'b0; d_we = 1'b0;
        d_be = 4'h0; d_addr = 32'h0; d_wdata = 32'h0; mem_rdata = 32'h0;

        // reset held with both ports requesting: no grants, all outputs 0
        drv_rst = 1'b0;
        set_if(1'b1, 32'h0000_0090); set_d(1'b1, 1'b0, 4'hF, 32'h0000_0080, 32'h0);
        repeat (3) begin
            step();
            chk("rst_no_dgnt", 32'(d_gnt), 32'h0);
            chk("rst_no_ignt", 32'(if_gnt), 32'h0);
        end
        drv_rst = 1'b1;
        step();
        chk("first_gnt_d", 32'(d_gnt), 32'h1);
        chk("first_gnt_i", 32'(if_gnt), 32'h0);
        idle_wait();

        // fetch at 0x10, memory returns 0x00500093
        set_if(1'b1, 32'h0000_0010);
        step(); chk("B_if_gnt", 32'(if_gnt), 32'h1);
        set_if(1'b0, 32'h0);
        repeat (L) begin
            step();
            chk("B_mem_en", 32'(mem_en), 32'h1);
            chk("B_mem_addr", mem_addr, 32'h0000_0010);
            chk("B_mem_we", 32'(mem_we), 32'h0);
        end
        step();
        chk("B_if_rvalid", 32'(if_rvalid), 32'h1);
        chk("B_if_rdata", if_rdata, 32'h0050_0093);

        // both request: store wins first, fetch follows after the response
        set_if(1'b1, 32'h0000_0200);
        set_d(1'b1, 1'b1, 4'hF, 32'h0000_0100, 32'hDEAD_BEEF);
        step(); chk("C_d_gnt", 32'(d_gnt), 32'h1); chk("C_if_gnt_T", 32'(if_gnt), 32'h0);
        set_d(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        repeat (L) begin step(); chk("C_mem_we", 32'(mem_we), 32'h1); end
        step(); chk("C_d_rvalid", 32'(d_rvalid), 32'h1); chk("C_d_rdata", d_rdata, 32'h0);
        step(); chk("C_if_gnt", 32'(if_gnt), 32'h1);
        set_if(1'b0, 32'h0);
        repeat (L) step();
        step(); chk("C_if_rvalid", 32'(if_rvalid), 32'h1);
        chk("C_if_rdata", if_rdata, mem_fn(32'h0000_0200));

        // reset in the first busy cycle of a load discards it
        set_d(1'b1, 1'b0, 4'hF, 32'h0000_0300, 32'h0);
        step(); chk("D_d_gnt", 32'(d_gnt), 32'h1);
        set_d(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drv_rst = 1'b0;
        step(); chk("D_mem_en_drop", 32'(mem_en), 32'h0);
        step();
        drv_rst = 1'b1;
        repeat (4) begin step(); chk("D_no_rvalid", 32'(d_rvalid), 32'h0); end
        set_if(1'b1, 32'h0000_0020);
        step(); chk("D_if_gnt", 32'(if_gnt), 32'h1);
        set_if(1'b0, 32'h0);
        repeat (L) step();
        step(); chk("D_if_rvalid", 32'(if_rvalid), 32'h1);
        chk("D_if_rdata", if_rdata, mem_fn(32'h0000_0020));
        step();

        // both held for 20 cycles
        grants.delete();
        set_if(1'b1, 32'h0000_0500); set_d(1'b1, 1'b0, 4'hF, 32'h0000_0400, 32'h0);
        repeat (20) step();
        idle_wait();
        chk("F_grant_count", 32'(grants.size()), 32'd5);
        for (int i = 0; i < grants.size(); i++)
            chk("F_grant_owner", 32'(grants[i]), 32'(RR ? (i % 2 == 0) : 1'b1));

        // fetch request raised only during BUSY is ignored
        set_d(1'b1, 1'b0, 4'hF, 32'h0000_0600, 32'h0);
        step();
        set_d(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        en_cnt = 0; ig_cnt = 0;
        for (int k = 1; k <= 6; k++) begin
            set_if(k == 1, 32'h0000_0700);
            step();
            en_cnt += int'(mem_en); ig_cnt += int'(if_gnt);
        end
        chk("E_mem_en_cycles", 32'(en_cnt), 32'(L));
        chk("E_no_if_gnt", 32'(ig_cnt), 32'h0);

        // vector table, each row from IDLE
        for (int v = 0; v < 4; v++) begin
            set_if(vecs[v].ir, vecs[v].addr);
            set_d(vecs[v].dr, vecs[v].we, vecs[v].be, vecs[v].addr, vecs[v].wdata);
            step();
            chk("V_d_gnt", 32'(d_gnt), 32'(vecs[v].exp_dg));
            chk("V_if_gnt", 32'(if_gnt), 32'(!vecs[v].exp_dg));
            set_if(1'b0, 32'h0); set_d(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            repeat (L) step();
            step();
            if (vecs[v].exp_dg) begin
                chk("V_d_rvalid", 32'(d_rvalid), 32'h1);
                chk("V_d_rdata", d_rdata, vecs[v].exp_rdata);
            end else begin
                chk("V_if_rvalid", 32'(if_rvalid), 32'h1);
                chk("V_if_rdata", if_rdata, vecs[v].exp_rdata);
            end
            step();
        end

        // randomized traffic with occasional resets and abandoned requests
        ron_i = 1'b0; ron_d = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!ron_i) begin
                ron_i = ($urandom_range(0, 2) == 0);
                drv_iaddr = $urandom;
            end else if ($urandom_range(0, 15) == 0) begin
                ron_i = 1'b0;
            end
            if (!ron_d) begin
                ron_d = ($urandom_range(0, 2) == 0);
                drv_we = 1'($urandom_range(0, 1));
                drv_be = 4'($urandom);
                drv_daddr = $urandom;
                drv_wdata = $urandom;
            end else if ($urandom_range(0, 15) == 0) begin
                ron_d = 1'b0;
            end
            drv_ir = ron_i; drv_dr = ron_d;
            drv_rst = ($urandom_range(0, 299) != 0);
            step();
            if (last_ig) ron_i = 1'b0;
            if (last_dg) ron_d = 1'b0;
        end
        drv_rst = 1'b1;
        idle_wait();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
